// File: rtl/oled_spi_tx_pkg.sv
// Shared types and constants for the OLED SPI byte transmitter.
package oled_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, DONE} state_e;

  localparam logic SCLK_IDLE = 1'b1;
  // Divider counter width; holds CLK_DIV-1 for CLK_DIV up to 255.
  localparam int DIV_W = 8;
endpackage

// File: rtl/oled_spi_tx_if.sv
// Request/response handshake between the OLED write sequencer and the SPI transmitter.
interface oled_spi_tx_if;
  logic       spi_send;
  logic [7:0] spi_data;
  logic       dc_in;
  logic       send_done;
  logic       busy;

  modport master (output spi_send, spi_data, dc_in, input send_done, busy);
  modport slave  (input spi_send, spi_data, dc_in, output send_done, busy);
endinterface

// File: rtl/oled_spi_tx_tick.sv
// Per-state interval divider: tick_o is high on the last cycle of every CLK_DIV-cycle interval.
module oled_spi_tick
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  // Wrapping on the tick means each new state starts its interval at zero.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/oled_spi_tx.sv
// MSB-first SPI byte transmitter (CPOL=1, CPHA=1) for the SSD1306 OLED panel.
// Optional OLED_SPI_BYTE_CNT_EN adds a free-running 16-bit count of completed bytes.
module oled_spi_tx
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  oled_spi_tx_if.slave      bus,
  output logic              oled_sclk,
  output logic              oled_sdin,
  output logic              oled_cs_n,
  output logic              oled_dc
`ifdef OLED_SPI_BYTE_CNT_EN
  ,
  output logic [15:0]       tx_byte_count
`endif
);
  state_e     state_q;
  logic [7:0] sr_q;
  logic [2:0] bit_cnt_q;
  logic       sclk_q, sdin_q, cs_n_q, dc_q, done_q, busy_q;
  logic       tick;

  oled_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clr_i  ((state_q == IDLE) || (state_q == DONE)),
    .tick_o (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= SCLK_IDLE;
      sdin_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      dc_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.spi_send) begin
          sr_q      <= bus.spi_data;
          sdin_q    <= bus.spi_data[7];
          dc_q      <= bus.dc_in;
          bit_cnt_q <= '0;
          cs_n_q    <= 1'b0;
          sclk_q    <= SCLK_IDLE;
          busy_q    <= 1'b1;
          state_q   <= SETUP;
        end
        SETUP: if (tick) begin
          sclk_q  <= ~SCLK_IDLE;
          state_q <= LOW;
        end
        LOW: if (tick) begin
          sclk_q  <= SCLK_IDLE;
          state_q <= HIGH;
        end
        // Next bit goes out together with the falling edge, so sdin is stable at every rise.
        HIGH: if (tick) begin
          if (bit_cnt_q == 3'd7) begin
            state_q <= HOLD;
          end else begin
            sr_q      <= {sr_q[6:0], 1'b0};
            sdin_q    <= sr_q[6];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            sclk_q    <= ~SCLK_IDLE;
            state_q   <= LOW;
          end
        end
        HOLD: if (tick) begin
          cs_n_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oled_sclk     = sclk_q;
  assign oled_sdin     = sdin_q;
  assign oled_cs_n     = cs_n_q;
  assign oled_dc       = dc_q;
  assign bus.send_done = done_q;
  assign bus.busy      = busy_q;

`ifdef OLED_SPI_BYTE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                cnt_q <= '0;
    else if (state_q == DONE) cnt_q <= cnt_q + 16'd1;
  end

  assign tx_byte_count = cnt_q;
`endif
endmodule

// File: tb/tb_oled_spi_tx.sv
// Directed + randomized bench for oled_spi_tx at CLK_DIV=4 (dut_a) and CLK_DIV=1 (dut_b).
module tb_oled_spi_tx;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  oled_spi_tx_if ifa ();
  oled_spi_tx_if ifb ();

  logic sclk_a, sdin_a, cs_a, dc_a, sclk_b, sdin_b, cs_b, dc_b;
`ifdef OLED_SPI_BYTE_CNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  oled_spi_tx #(.CLK_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa),
    .oled_sclk(sclk_a), .oled_sdin(sdin_a), .oled_cs_n(cs_a), .oled_dc(dc_a)
`ifdef OLED_SPI_BYTE_CNT_EN
    , .tx_byte_count(cnt_a)
`endif
  );

  oled_spi_tx #(.CLK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb),
    .oled_sclk(sclk_b), .oled_sdin(sdin_b), .oled_cs_n(cs_b), .oled_dc(dc_b)
`ifdef OLED_SPI_BYTE_CNT_EN
    , .tx_byte_count(cnt_b)
`endif
  );

  bit   sel;  // 0 observes dut_a, 1 observes dut_b
  logic o_sclk, o_sdin, o_cs, o_dc, o_done, o_busy;
  assign o_sclk = sel ? sclk_b : sclk_a;
  assign o_sdin = sel ? sdin_b : sdin_a;
  assign o_cs   = sel ? cs_b   : cs_a;
  assign o_dc   = sel ? dc_b   : dc_a;
  assign o_done = sel ? ifb.send_done : ifa.send_done;
  assign o_busy = sel ? ifb.busy      : ifa.busy;

  int checks = 0;
  int errors = 0;
  int frames_a = 0;
  logic [7:0] bq[$];
  logic       dq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit send, input logic [7:0] data, input logic dc);
    if (sel) ifb.spi_send = send; else ifa.spi_send = send;
    ifa.spi_data = data; ifb.spi_data = data;
    ifa.dc_in    = dc;   ifb.dc_in    = dc;
  endtask

  // Sends bytes[] back to back on the selected DUT and checks each frame against the
  // reference timing: CS low 18*div cycles, bits MSB-first on sclk rises, done at 18*div+1.
  task automatic xfer(input bit s, input logic [7:0] bytes[$], input logic dcs[$], input int drop_at);
    int div, cs_lo, cs_hi, dc_bad, nb, done_k;
    logic [7:0] got;
    logic prev_sclk;
    div = s ? 1 : 4;
    @(negedge clk);
    sel = s;
    drive(1'b1, bytes[0], dcs[0]);
    for (int f = 0; f < bytes.size(); f++) begin
      cs_lo = 0; cs_hi = 0; dc_bad = 0; nb = 0; got = '0; done_k = -1;
      prev_sclk = 1'b1;
      for (int k = 0; k <= 18 * div + 8; k++) begin
        @(posedge clk); #1;
        if (k == drop_at) drive(1'b0, 8'h00, ~dcs[f]);
        if (o_cs === 1'b0) begin
          cs_lo++;
          if (o_dc !== dcs[f]) dc_bad++;
        end else cs_hi++;
        if (o_sclk === 1'b1 && prev_sclk === 1'b0) begin
          got = {got[6:0], o_sdin};
          nb++;
        end
        prev_sclk = o_sclk;
        if (o_done === 1'b1) begin done_k = k; break; end
      end
      chk("done_latency", done_k, 18 * div + 1);
      chk("bits", got, bytes[f]);
      chk("bit_count", nb, 8);
      chk("cs_low_cycles", cs_lo, 18 * div);
      chk("cs_high_gap", cs_hi, 2);
      chk("dc_held", dc_bad, 0);
      chk("busy_at_done", o_busy, 1'b0);
      if (!s && done_k >= 0) frames_a++;
      if (f + 1 < bytes.size()) drive(1'b1, bytes[f+1], dcs[f+1]);
      else drive(1'b0, bytes[f], dcs[f]);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", o_done, 1'b0);
    chk("idle_cs_high", o_cs, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    sel = 1'b0; drive(1'b0, 8'h00, 1'b0);
    sel = 1'b1; drive(1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      sel = bit'(i);
      #1;
      chk("reset_outputs", {o_sclk, o_cs, o_sdin, o_dc, o_done, o_busy}, 6'b110000);
    end
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);

    // Basic byte, dc=1
    bq = '{8'hA5}; dq = '{1'b1};
    xfer(1'b0, bq, dq, -1);

    // Chained frames with spi_send held high
    bq = '{8'hB0, 8'h10, 8'h00}; dq = '{1'b0, 1'b1, 1'b0};
    xfer(1'b0, bq, dq, -1);

    // Request dropped and inputs changed mid-transfer
    bq = '{8'hFF}; dq = '{1'b1};
    xfer(1'b0, bq, dq, 10);

    // Fastest divider
    bq = '{8'h81}; dq = '{1'b0};
    xfer(1'b1, bq, dq, -1);

    // Randomized single bytes and a random chain on both dividers
    for (int i = 0; i < 4; i++) begin
      bq = '{8'($urandom)}; dq = '{1'($urandom)};
      xfer(1'($urandom_range(0, 1)), bq, dq, -1);
    end
    bq = '{8'($urandom), 8'($urandom), 8'($urandom)};
    dq = '{1'($urandom), 1'($urandom), 1'($urandom)};
    xfer(1'b1, bq, dq, -1);

`ifdef OLED_SPI_BYTE_CNT_EN
    chk("byte_count", cnt_a, 16'(frames_a));
`endif

    // Reset 30 cycles into a transfer aborts it on the spot
    @(negedge clk);
    sel = 1'b0;
    drive(1'b1, 8'h3C, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 8'h3C, 1'b1);
    repeat (29) @(posedge clk);
    #2;
    chk("pre_abort_cs_low", o_cs, 1'b0);
    reset = 1'b1;
    #1;
    chk("abort_cs_sclk", {o_cs, o_sclk}, 2'b11);
    chk("abort_busy", o_busy, 1'b0);
    frames_a = 0;
    @(negedge clk) reset = 1'b0;
    begin
      int dones, lows;
      dones = 0; lows = 0;
      for (int k = 0; k < 100; k++) begin
        @(posedge clk); #1;
        if (o_done !== 1'b0) dones++;
        if (o_cs !== 1'b1) lows++;
      end
      chk("abort_no_done", dones, 0);
      chk("abort_stays_idle", lows, 0);
    end

    // Recovery after abort
    bq = '{8'h5A, 8'hC3, 8'h0F}; dq = '{1'b1, 1'b0, 1'b1};
    xfer(1'b0, bq, dq, -1);
`ifdef OLED_SPI_BYTE_CNT_EN
    chk("byte_count_after_reset", cnt_a, 16'(frames_a));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
